// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants, used by both transmit and receive sides
package uart_pkg;

    localparam int UART_DATA_W = 8;

    localparam logic PARITY_MODE_EVEN = 1'b0;
    localparam logic PARITY_MODE_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    function automatic logic parity_bit(input logic [UART_DATA_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// rtl/uart_tx_serializer_if.sv - bridge-to-serializer byte request and status signals
interface uart_tx_serializer_if;
    import uart_pkg::*;

    logic                   tx_en;
    logic                   txStart;
    logic [UART_DATA_W-1:0] txData;
    logic                   tx;
    logic                   busy;
    logic                   txDone;
    logic                   err;

    modport master (
        output tx_en, txStart, txData,
        input  tx, busy, txDone, err
    );

    modport slave (
        input  tx_en, txStart, txData,
        output tx, busy, txDone, err
    );

endinterface

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running bit-period divider with a one-cycle end-of-bit tick
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_bit_tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_bit_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - serializes one start/data/parity/stop frame per bridge byte request
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_serializer_if.slave  bus
);

    localparam logic [2:0] LAST_STOP  = 3'(STOP_BITS - 1);
    localparam logic       PAR_ODD    = (PARITY_ODD != 0);
    localparam bit         HAS_PARITY = (PARITY_EN != 0);

    uart_state_t            r_state, w_state_nxt;
    logic [UART_DATA_W-1:0] r_shift, w_shift_nxt;
    logic [2:0]             r_bit_cnt, w_bit_cnt_nxt;
    logic                   r_par, w_par_nxt;
    logic                   r_tx, w_tx_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_done, w_done_nxt;
    logic                   r_err, w_err_nxt;
    logic                   r_start_q;
    logic                   w_req;
    logic                   w_accept;
    logic                   w_bit_tick;

    // Only a rising edge of the request level counts, so a held level sends one frame.
    assign w_req    = bus.txStart & ~r_start_q;
    assign w_accept = w_req & bus.tx_en & (r_state == IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_accept),
        .o_bit_tick (w_bit_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_par     <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_start_q <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_par     <= w_par_nxt;
            r_tx      <= w_tx_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_start_q <= bus.txStart;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_par_nxt     = r_par;
        w_tx_nxt      = r_tx;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_err_nxt     = w_req & r_busy;
        case (r_state)
            IDLE: begin
                w_tx_nxt = 1'b1;
                if (w_accept) begin
                    w_state_nxt   = START;
                    w_shift_nxt   = bus.txData;
                    w_par_nxt     = parity_bit(bus.txData, PAR_ODD);
                    w_bit_cnt_nxt = '0;
                    w_tx_nxt      = 1'b0;
                    w_busy_nxt    = 1'b1;
                end
            end
            START: begin
                if (w_bit_tick) begin
                    w_state_nxt = DATA;
                    w_tx_nxt    = r_shift[0];
                end
            end
            DATA: begin
                if (w_bit_tick) begin
                    w_shift_nxt   = r_shift >> 1;
                    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = HAS_PARITY ? PARITY : STOP;
                        w_tx_nxt    = HAS_PARITY ? r_par : 1'b1;
                    end else begin
                        w_tx_nxt = r_shift[1];
                    end
                end
            end
            PARITY: begin
                if (w_bit_tick) begin
                    w_state_nxt = STOP;
                    w_tx_nxt    = 1'b1;
                end
            end
            STOP: begin
                // The bit counter wrapped to 0 leaving DATA and now counts stop bits.
                if (w_bit_tick) begin
                    if (r_bit_cnt == LAST_STOP) begin
                        w_state_nxt   = IDLE;
                        w_bit_cnt_nxt = '0;
                        w_busy_nxt    = 1'b0;
                        w_done_nxt    = 1'b1;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign bus.tx     = r_tx;
    assign bus.busy   = r_busy;
    assign bus.txDone = r_done;
    assign bus.err    = r_err;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - scoreboard bench over four parity/stop-bit configurations
module tb_uart_tx_serializer;

    localparam int CPB = 4;
    localparam int NDUT = 4;

    function automatic int pen_of(input int d);
        return (d == 1 || d == 2) ? 1 : 0;
    endfunction
    function automatic int podd_of(input int d);
        return (d == 2) ? 1 : 0;
    endfunction
    function automatic int sb_of(input int d);
        return (d == 3) ? 2 : 1;
    endfunction

    typedef struct packed {
        logic [7:0]  data;
        logic [23:0] cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] s_en = 4'h0;
    logic [3:0] s_start = 4'h0;
    logic [7:0] s_data [NDUT];
    wire  [3:0] o_tx, o_busy, o_done, o_err;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q [NDUT][$];
    int   err_q [NDUT][$];

    bit   m_in   [NDUT];
    int   m_k    [NDUT];
    int   m_n    [NDUT];
    logic m_bits [NDUT][16];
    bit   prev_rst = 1'b0;

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        uart_tx_serializer_if u_if ();
        assign u_if.tx_en   = s_en[g];
        assign u_if.txStart = s_start[g];
        assign u_if.txData  = s_data[g];
        assign o_tx[g]      = u_if.tx;
        assign o_busy[g]    = u_if.busy;
        assign o_done[g]    = u_if.txDone;
        assign o_err[g]     = u_if.err;

        uart_tx_serializer #(
            .CLKS_PER_BIT (CPB),
            .PARITY_EN    (pen_of(g)),
            .PARITY_ODD   (podd_of(g)),
            .STOP_BITS    (sb_of(g))
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (u_if)
        );
    end

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d cyc=%0d actual=%0h expected=%0h", name, d, cyc, act, exp);
        end
    endtask

    // Reference frame: start, data LSB first, optional parity, stop bits; one entry per bit period.
    task automatic load_frame(input int d, input logic [7:0] b);
        int nb;
        m_bits[d][0] = 1'b0;
        for (int i = 0; i < 8; i++) m_bits[d][1 + i] = b[i];
        nb = 9;
        if (pen_of(d) != 0) begin
            m_bits[d][nb] = (($countones(b) % 2) ^ podd_of(d)) != 0;
            nb = nb + 1;
        end
        for (int s = 0; s < sb_of(d); s++) begin
            m_bits[d][nb] = 1'b1;
            nb = nb + 1;
        end
        m_n[d] = nb * CPB;
        m_k[d] = 0;
        m_in[d] = 1'b1;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                if (prev_rst) begin
                    check("rst_tx", d, o_tx[d], 1);
                    check("rst_busy", d, o_busy[d], 0);
                    check("rst_done", d, o_done[d], 0);
                    check("rst_err", d, o_err[d], 0);
                    m_in[d] = 1'b0;
                    exp_q[d].delete();
                    err_q[d].delete();
                end else begin
                    if (err_q[d].size() > 0 && err_q[d][0] == cyc) begin
                        check("err_pulse", d, o_err[d], 1);
                        void'(err_q[d].pop_front());
                    end else begin
                        check("err_quiet", d, o_err[d], 0);
                    end
                    if (!m_in[d]) begin
                        if (exp_q[d].size() > 0 && int'(exp_q[d][0].cyc) <= cyc) begin
                            e = exp_q[d].pop_front();
                            check("start_cycle", d, cyc, int'(e.cyc));
                            check("start_bit", d, o_tx[d], 0);
                            load_frame(d, e.data);
                        end else begin
                            check("idle_tx", d, o_tx[d], 1);
                            check("idle_busy", d, o_busy[d], 0);
                            check("idle_done", d, o_done[d], 0);
                        end
                    end
                    if (m_in[d]) begin
                        if (m_k[d] < m_n[d]) begin
                            check("frame_tx", d, o_tx[d], m_bits[d][m_k[d] / CPB]);
                            check("frame_busy", d, o_busy[d], 1);
                            check("frame_done", d, o_done[d], 0);
                        end else begin
                            check("end_done", d, o_done[d], 1);
                            check("end_busy", d, o_busy[d], 0);
                            check("end_tx", d, o_tx[d], 1);
                            m_in[d] = 1'b0;
                        end
                        m_k[d]++;
                    end
                end
            end
            prev_rst = rst;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic request(input int d, input logic [7:0] b, input bit expect_acc);
        exp_t e;
        s_data[d]  = b;
        s_start[d] = 1'b1;
        if (expect_acc) begin
            e.data = b;
            e.cyc  = 24'(cyc + 1);
            exp_q[d].push_back(e);
        end
    endtask

    task automatic busy_request(input int d);
        s_data[d]  = 8'($urandom);
        s_start[d] = 1'b1;
        err_q[d].push_back(cyc + 1);
    endtask

    task automatic wait_done(input int d);
        int n = 0;
        do begin
            tick(1);
            n++;
        end while (!o_done[d] && n < 200);
        check("done_seen", d, o_done[d], 1);
    endtask

    initial begin
        logic [7:0] burst [4];
        int mode;
        fork
            monitor();
        join_none
        for (int d = 0; d < NDUT; d++) s_data[d] = 8'h00;
        tick(3);
        rst  = 1'b0;
        s_en = 4'hF;
        tick(2);

        // 0xA5 frame, then txStart held for 100 cycles must not retrigger
        request(0, 8'hA5, 1);
        wait_done(0);
        tick(100);
        s_start[0] = 1'b0;
        tick(1);

        burst = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            request(0, burst[i], 1);
            wait_done(0);
            s_start[0] = 1'b0;
            tick(1);
        end

        // New rise inside the txDone cycle: frames with no idle gap
        request(0, 8'($urandom), 1);
        tick(2);
        s_start[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_done(0);
            request(0, 8'($urandom), 1);
            tick(2);
            s_start[0] = 1'b0;
        end
        wait_done(0);
        tick(2);

        for (int d = 1; d < NDUT; d++) begin
            request(d, 8'h07, 1);
            wait_done(d);
            s_start[d] = 1'b0;
            tick(1);
        end

        // Mid-frame request is rejected with a single err pulse
        request(0, 8'h5A, 1);
        tick(4);
        s_start[0] = 1'b0;
        tick(5);
        busy_request(0);
        wait_done(0);
        tick(3);
        s_start[0] = 1'b0;
        tick(2);

        s_en[0] = 1'b0;
        request(0, 8'h3C, 0);
        tick(60);
        s_start[0] = 1'b0;
        s_en[0] = 1'b1;
        tick(2);

        request(0, 8'h69, 1);
        tick(8);
        s_en[0] = 1'b0;
        wait_done(0);
        s_start[0] = 1'b0;
        s_en[0] = 1'b1;
        tick(2);

        request(0, 8'hC3, 1);
        tick(20);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        s_start[0] = 1'b0;
        tick(3);
        request(0, 8'h96, 1);
        wait_done(0);
        s_start[0] = 1'b0;
        tick(1);

        for (int it = 0; it < 30; it++) begin
            int d;
            d    = $urandom_range(0, NDUT - 1);
            mode = $urandom_range(0, 2);
            tick($urandom_range(0, 3));
            request(d, 8'($urandom), 1);
            tick(3);
            if (mode == 1) begin
                s_en[d] = 1'b0;
            end else if (mode == 2) begin
                s_start[d] = 1'b0;
                tick($urandom_range(1, 20));
                busy_request(d);
            end
            wait_done(d);
            s_start[d] = 1'b0;
            s_en[d] = 1'b1;
            tick(1);
        end

        tick(5);
        for (int d = 0; d < NDUT; d++) begin
            check("exp_drained", d, exp_q[d].size(), 0);
            check("err_drained", d, err_q[d].size(), 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
